// File: rtl/rr_grant_ctrl_pkg.sv
// Shared widths, FSM encoding and defaults for the round-robin grant controller.
package rr_grant_ctrl_pkg;

   localparam int NUM_REQ          = 4;
   localparam int IDX_W            = 2;
   localparam int DEFAULT_MAX_HOLD = 16;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   typedef logic [NUM_REQ-1:0] req_vec_t;
   typedef logic [IDX_W-1:0]   req_idx_t;

endpackage

// File: rtl/rr_grant_ctrl_if.sv
// Requester-side bundle of the arbiter: request/release inputs and grant/status outputs.
interface rr_grant_ctrl_if;
   import rr_grant_ctrl_pkg::*;

   req_vec_t Req;
   req_vec_t Done;
   req_vec_t Grant;
   logic     Grant_Valid;
   req_idx_t Grant_Id;
   logic     Timeout;
   req_idx_t Ptr;

   modport master (
      output Req, Done,
      input  Grant, Grant_Valid, Grant_Id, Timeout, Ptr
   );

   modport slave (
      input  Req, Done,
      output Grant, Grant_Valid, Grant_Id, Timeout, Ptr
   );

endinterface

// File: rtl/rr_rotate4.sv
// Combinational 4-bit ring rotate-left: dout[i] = din[(i - amt) mod 4].
module rr_rotate4 (
   input  logic [3:0] din,
   input  logic [1:0] amt,
   output logic [3:0] dout
);

   always_comb begin
      case (amt)
         2'd0:    dout = din;
         2'd1:    dout = {din[2:0], din[3]};
         2'd2:    dout = {din[1:0], din[3:2]};
         default: dout = {din[0], din[3:1]};
      endcase
   end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Four-way round-robin arbiter: grants are held until Done, request drop or hold
// limit, followed by one idle cycle in which the next winner is chosen.
module rr_grant_ctrl
   import rr_grant_ctrl_pkg::*;
#(
   parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
   parameter int CNT_W    = 5
) (
   input logic            Clk,
   input logic            Rst_n,
   rr_grant_ctrl_if.slave bus
);

   localparam bit               HAS_LIMIT = (MAX_HOLD != 0);
   localparam logic [CNT_W-1:0] LIMIT     = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

   logic [0:0]       state_q;
   req_vec_t         grant_q;
   logic             grant_valid_q;
   req_idx_t         grant_id_q;
   logic             timeout_q;
   req_idx_t         ptr_q;
   logic [CNT_W-1:0] cnt_q;

   req_idx_t align_amt;
   req_vec_t aligned_req;
   req_vec_t aligned_win;
   req_vec_t win_onehot;
   req_idx_t win_id;

   logic own_done;
   logic own_req;
   logic at_limit;
   logic release_now;

   // Rotate so the pointer position sits at bit 0, pick the lowest set bit, rotate back.
   assign align_amt   = 2'd0 - ptr_q;
   assign aligned_win = aligned_req & (~aligned_req + 4'd1);

   rr_rotate4 u_align (
      .din  (bus.Req),
      .amt  (align_amt),
      .dout (aligned_req)
   );

   rr_rotate4 u_restore (
      .din  (aligned_win),
      .amt  (ptr_q),
      .dout (win_onehot)
   );

   always_comb begin
      win_id = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_onehot[i]) win_id = req_idx_t'(i);
      end
   end

   assign own_done    = bus.Done[grant_id_q];
   assign own_req     = bus.Req[grant_id_q];
   assign at_limit    = HAS_LIMIT && (cnt_q == LIMIT);
   assign release_now = own_done || !own_req || at_limit;

   // Timeout is asserted only when the hold limit is the sole reason for release.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q       <= ST_IDLE;
         grant_q       <= '0;
         grant_valid_q <= 1'b0;
         grant_id_q    <= '0;
         timeout_q     <= 1'b0;
         ptr_q         <= '0;
         cnt_q         <= '0;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (|bus.Req) begin
                  grant_q       <= win_onehot;
                  grant_valid_q <= 1'b1;
                  grant_id_q    <= win_id;
                  cnt_q         <= '0;
                  state_q       <= ST_GRANT;
               end
            end
            default: begin
               if (release_now) begin
                  grant_q       <= '0;
                  grant_valid_q <= 1'b0;
                  ptr_q         <= grant_id_q + 2'd1;
                  timeout_q     <= !own_done && own_req;
                  state_q       <= ST_IDLE;
               end else begin
                  cnt_q <= (&cnt_q) ? cnt_q : cnt_q + 1'b1;
               end
            end
         endcase
      end
   end

   assign bus.Grant       = grant_q;
   assign bus.Grant_Valid = grant_valid_q;
   assign bus.Grant_Id    = grant_id_q;
   assign bus.Timeout     = timeout_q;
   assign bus.Ptr         = ptr_q;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Randomised scoreboard bench for rr_grant_ctrl against a cycle-level behavioural model.
module tb_rr_grant_ctrl;

   localparam int MAX_HOLD = 4;
   localparam int CNT_W    = 3;

   typedef struct packed {
      logic [3:0] grant;
      logic       valid;
      logic [1:0] id;
      logic       timeout;
      logic [1:0] ptr;
   } exp_t;

   logic clk;
   logic rst_n;

   rr_grant_ctrl_if bus ();

   rr_grant_ctrl #(
      .MAX_HOLD (MAX_HOLD),
      .CNT_W    (CNT_W)
   ) dut (
      .Clk   (clk),
      .Rst_n (rst_n),
      .bus   (bus)
   );

   exp_t exp_q[$];
   int   total_checks = 0;
   int   bad_checks   = 0;
   bit   drive_done   = 1'b0;

   int m_owner   = -1;
   int m_held    = 0;
   int m_ptr     = 0;
   int m_id      = 0;
   bit m_timeout = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one cycle of inputs and predicts the outputs after the coming edge.
   task automatic applyStimulus(input logic [3:0] req, input logic [3:0] done, input bit rst);
      exp_t e;
      bit   found;
      bit   dn;
      bit   rq;
      bit   lim;
      bus.Req  = req;
      bus.Done = done;
      rst_n    = !rst;
      if (rst) begin
         m_owner   = -1;
         m_held    = 0;
         m_ptr     = 0;
         m_id      = 0;
         m_timeout = 1'b0;
      end else begin
         m_timeout = 1'b0;
         if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
               if (!found && req[(m_ptr + k) % 4]) begin
                  found   = 1'b1;
                  m_owner = (m_ptr + k) % 4;
                  m_id    = m_owner;
                  m_held  = 1;
               end
            end
         end else begin
            dn  = done[m_owner];
            rq  = req[m_owner];
            lim = (MAX_HOLD != 0) && (m_held >= MAX_HOLD);
            if (dn || !rq || lim) begin
               m_timeout = lim && !dn && rq;
               m_ptr     = (m_owner + 1) % 4;
               m_owner   = -1;
            end else begin
               m_held++;
            end
         end
      end
      e.grant   = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
      e.valid   = (m_owner >= 0);
      e.id      = 2'(m_id);
      e.timeout = m_timeout;
      e.ptr     = 2'(m_ptr);
      exp_q.push_back(e);
   endtask

   task automatic stepCycle(input logic [3:0] req, input logic [3:0] done, input bit rst);
      @(posedge clk);
      #2;
      applyStimulus(req, done, rst);
   endtask

   task automatic checkOutput(input exp_t e);
      exp_t act;
      act = {bus.Grant, bus.Grant_Valid, bus.Grant_Id, bus.Timeout, bus.Ptr};
      total_checks++;
      if (act !== e) begin
         bad_checks++;
         $display("[TB] FAIL outputs t=%0t: got grant=%b valid=%b id=%0d timeout=%b ptr=%0d, want grant=%b valid=%b id=%0d timeout=%b ptr=%0d",
                  $time, act.grant, act.valid, act.id, act.timeout, act.ptr,
                  e.grant, e.valid, e.id, e.timeout, e.ptr);
      end
   endtask

   // Monitor: compares whatever the DUT presents just after each edge with the oldest prediction.
   initial begin
      while (!drive_done || exp_q.size() > 0) begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
      end
   end

   initial begin
      logic [3:0] req_r;
      logic [3:0] done_r;
      bit         rst_r;

      applyStimulus(4'b0000, 4'b0000, 1'b1);
      stepCycle(4'b0000, 4'b0000, 1'b1);
      stepCycle(4'b0000, 4'b0000, 1'b0);

      for (int i = 0; i < 24; i++)
         stepCycle(4'b1111, (i % 3 == 2) ? 4'b1111 : 4'b0000, 1'b0);

      for (int i = 0; i < 14; i++) stepCycle(4'b0100, 4'b0000, 1'b0);

      for (int i = 0; i < 20; i++) stepCycle(4'b1111, 4'b0000, 1'b0);

      for (int i = 0; i < 6; i++) stepCycle(4'b0010, (i == 3) ? 4'b0101 : 4'b0000, 1'b0);
      stepCycle(4'b0010, 4'b0010, 1'b0);

      for (int i = 0; i < 3; i++) stepCycle(4'b1000, 4'b0000, 1'b0);
      stepCycle(4'b0000, 4'b0000, 1'b0);
      stepCycle(4'b0000, 4'b0000, 1'b0);

      for (int i = 0; i < 3; i++) stepCycle(4'b1000, 4'b0000, 1'b0);
      stepCycle(4'b1000, 4'b0000, 1'b1);
      for (int i = 0; i < 3; i++) stepCycle(4'b1000, 4'b0000, 1'b0);

      req_r = 4'b0000;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(7) == 0) req_r = 4'($urandom);
         done_r = ($urandom_range(5) == 0) ? 4'($urandom) : 4'b0000;
         rst_r  = ($urandom_range(79) == 0);
         stepCycle(req_r, done_r, rst_r);
      end

      drive_done = 1'b1;
      repeat (4) @(posedge clk);
      #3;
      total_checks++;
      if (exp_q.size() != 0) begin
         bad_checks++;
         $display("[TB] FAIL drain: got %0d pending predictions, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end

endmodule
